// File: rtl/gate_sequencer.sv
// Frequency-meter measurement controller: opens a gate of selectable length, counts
// synchronized SigIn rising edges inside it, and publishes the count over valid/ack.
module gate_sequencer #(
    parameter int unsigned CNT_WIDTH  = 22,
    parameter int unsigned GATE0_CYC  = 500000,
    parameter int unsigned GATE1_CYC  = 5000000,
    parameter int unsigned GATE2_CYC  = 50000000,
    parameter int unsigned HOLD_CYC   = 25000000,
    parameter int unsigned LOW_THRESH = 1000
) (
    input  logic                 ClkRef,
    input  logic                 RstN,
    input  logic                 SigIn,
    input  logic                 Run,
    input  logic                 AutoRange,
    input  logic [1:0]           RangeSel,
    input  logic                 ResultAck,
    output logic [CNT_WIDTH-1:0] Count,
    output logic [1:0]           Range,
    output logic                 Overflow,
    output logic                 ResultValid,
    output logic                 GateOut,
    output logic                 Busy
);

    typedef enum logic [2:0] {IDLE, ARM, GATE, LATCH, WAIT_ACK, HOLD} state_t;

    state_t               state;
    logic                 sync1, sync2, hist;
    logic                 edge_pulse;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic                 ovf;
    logic [1:0]           work_range;
    logic [1:0]           arm_range;
    logic [31:0]          timer;
    logic [31:0]          gate_len;
    logic [31:0]          cnt_ext;

    assign edge_pulse = sync2 & ~hist;
    assign cnt_ext    = 32'(edge_cnt);

    // Range used by the upcoming gate: manual mode takes RangeSel (3 folds to 2).
    always_comb begin
        arm_range = work_range;
        if (!AutoRange)
            arm_range = (RangeSel == 2'd3) ? 2'd2 : RangeSel;
        case (arm_range)
            2'd0:    gate_len = GATE0_CYC;
            2'd1:    gate_len = GATE1_CYC;
            default: gate_len = GATE2_CYC;
        endcase
    end

    always_ff @(posedge ClkRef) begin
        if (!RstN) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            hist        <= 1'b0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
            work_range  <= 2'd0;
            timer       <= '0;
            Count       <= '0;
            Range       <= 2'd0;
            Overflow    <= 1'b0;
            ResultValid <= 1'b0;
            GateOut     <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            sync1 <= SigIn;
            sync2 <= sync1;
            hist  <= sync2;
            case (state)
                IDLE: begin
                    if (Run) begin
                        state <= ARM;
                        Busy  <= 1'b1;
                    end
                end
                ARM: begin
                    edge_cnt   <= '0;
                    ovf        <= 1'b0;
                    work_range <= arm_range;
                    timer      <= gate_len;
                    GateOut    <= 1'b1;
                    state      <= GATE;
                end
                GATE: begin
                    if (edge_pulse) begin
                        if (edge_cnt == '1)
                            ovf <= 1'b1;
                        else
                            edge_cnt <= edge_cnt + 1'b1;
                    end
                    timer <= timer - 32'd1;
                    if (timer <= 32'd1) begin
                        GateOut <= 1'b0;
                        state   <= LATCH;
                    end
                end
                LATCH: begin
                    // Auto re-runs go straight back to ARM regardless of Run.
                    if (AutoRange && ovf && work_range != 2'd0) begin
                        work_range <= work_range - 2'd1;
                        state      <= ARM;
                    end else if (AutoRange && cnt_ext < LOW_THRESH && work_range < 2'd2) begin
                        work_range <= work_range + 2'd1;
                        state      <= ARM;
                    end else begin
                        Count       <= edge_cnt;
                        Range       <= work_range;
                        Overflow    <= ovf;
                        ResultValid <= 1'b1;
                        state       <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ResultAck) begin
                        ResultValid <= 1'b0;
                        timer       <= HOLD_CYC;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    timer <= timer - 32'd1;
                    if (timer <= 32'd1) begin
                        if (Run) begin
                            state <= ARM;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gate_sequencer.md
Name: gate_sequencer

Overview:
- Measurement controller for the frequency meter datapath, clocked by the reference clock.
- Opens a measurement gate of selectable length and counts rising edges of the measured signal inside it.
- Latches the result and hands it to the frequency/period calculation stage over a valid/ack handshake.
- Optional auto-ranging re-runs the measurement on a longer or shorter gate until the count is in range.

Parameters:
- CNT_WIDTH, 22, width of the edge counter and of Count.
- GATE0_CYC, 500000, gate length in ClkRef cycles for range 0 (10 ms at 50 MHz).
- GATE1_CYC, 5000000, gate length for range 1 (100 ms).
- GATE2_CYC, 50000000, gate length for range 2 (1 s).
- HOLD_CYC, 25000000, display hold time in cycles between consecutive measurements.
- LOW_THRESH, 1000, auto-range step-up threshold: a count below this moves to a longer gate.

Ports:
- ClkRef  in  1  reference clock, the only clock.
- RstN  in  1  synchronous, active-low reset.
- SigIn  in  1  measured signal, asynchronous to ClkRef.
- Run  in  1  1 = continuous measurements; 0 = stop after the current measurement.
- AutoRange  in  1  1 = automatic range selection; 0 = use RangeSel.
- RangeSel  in  2  manual range (0..2; 3 is treated as 2).
- ResultAck  in  1  downstream has consumed the result.
- Count  out  CNT_WIDTH  latched edge count.
- Range  out  2  range used for the latched Count.
- Overflow  out  1  the latched count saturated.
- ResultValid  out  1  Count/Range/Overflow are valid.
- GateOut  out  1  high during the counting window.
- Busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: RstN sampled low on a ClkRef edge forces:
  - state IDLE, Count=0, Range=0, Overflow=0, ResultValid=0, GateOut=0, Busy=0;
  - synchronizer cleared, edge counter and gate timer cleared.
- Reset asserted mid-operation aborts the measurement. No partial result is ever published.
- Input path:
  - SigIn passes through a 2-FF synchronizer plus one history register.
  - Edge pulse = sync2 & ~hist. Edges reach the counter 2 cycles after SigIn.
- States: IDLE, ARM, GATE, LATCH, WAIT_ACK, HOLD.
- IDLE:
  - Run=1 -> ARM. Otherwise stay.
- ARM (1 cycle):
  - Clear the edge counter.
  - Manual mode: the working range register takes RangeSel.
  - Auto mode: the working range register keeps its value.
  - Load the gate timer with GATEn_CYC for the working range.
  - Next state GATE.
- GATE:
  - GateOut=1 for exactly GATEn_CYC cycles.
  - An edge pulse in any of those cycles increments the counter.
  - The counter saturates at 2^CNT_WIDTH-1. An increment attempted at saturation sets an internal ovf flag.
  - After the last gate cycle -> LATCH.
- LATCH (1 cycle), evaluated in this order:
  1. Auto mode, ovf=1, range>0: range-1, discard the result, -> ARM.
  2. Auto mode, count<LOW_THRESH, range<2: range+1, discard, -> ARM.
  3. Otherwise: Count<=counter, Range<=range, Overflow<=ovf, ResultValid<=1, -> WAIT_ACK.
  - Consequence: an auto-mode overflow at range 0 and a low count at range 2 are both published.
- WAIT_ACK:
  - Outputs are held stable while ResultValid=1.
  - ResultAck=1 sampled in this state: ResultValid<=0 on the next edge, -> HOLD.
  - ResultAck while ResultValid=0 is ignored.
  - ResultAck may already be high when ResultValid rises; it is then taken in the first WAIT_ACK cycle.
- HOLD:
  - Count HOLD_CYC cycles. Count/Range/Overflow keep their last values.
  - At the end: Run=1 -> ARM, else -> IDLE.
- Run deasserted in ARM/GATE/LATCH does not abort: the measurement completes and publishes (including auto re-runs), then returns to IDLE after HOLD.
- The working range persists across measurements and is not reset by Run.
- Timing: from Run=1 sampled in IDLE, the first GateOut cycle is 2 edges later (IDLE->ARM->GATE). ResultValid rises on the edge after the LATCH cycle.
- Busy=1 in all states except IDLE.

Test Plan:
All scenarios use CNT_WIDTH=8, GATE0/1/2=10/100/1000, HOLD_CYC=4, LOW_THRESH=20.
- Reset: hold RstN=0 for 3 cycles with Run=1 and SigIn toggling -> all outputs 0, state IDLE. Release RstN -> GateOut rises on the 2nd edge after release.
- Manual range 2: SigIn period of 4 cycles, aligned -> one publish, ResultValid=1, Count=250, Range=2, Overflow=0. GateOut high for exactly 1000 cycles.
- Manual overflow: SigIn period of 2 cycles, range 2 -> Count=255, Overflow=1, Range=2.
- Auto up-range: period 4, start at range 0 -> range-0 result discarded (count<20, ResultValid stays 0) -> published Count=25, Range=1.
- Auto down-range: period 2, working range preset to 2 via a prior run -> overflow discarded -> Count=50, Range=1, Overflow=0.
- Handshake:
  - ResultAck withheld for 50 cycles -> ResultValid and Count stay stable.
  - Pulse ResultAck -> ResultValid=0 on the next edge, then a 4-cycle HOLD.
  - Drop Run mid-GATE -> the measurement publishes, then Busy=0 after HOLD.
  - Assert RstN=0 mid-GATE -> no publish, IDLE.
